// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate byte data cache in front of a
// 64-block x 32-bit memory. Hits complete with no stall; misses run writeback/fetch.
module dcache_controller #(
    parameter int TAG_W = 3,
    parameter int IDX_W = 3,
    parameter int OFF_W = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     read,
    input  logic                     write,
    input  logic [7:0]               address,
    input  logic [7:0]               writedata,
    output logic [7:0]               readdata,
    output logic                     busywait,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [TAG_W+IDX_W-1:0]   mem_address,
    output logic [31:0]              mem_writedata,
    input  logic [31:0]              mem_readdata,
    input  logic                     mem_busywait
);

    localparam int LINES = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

    state_t                   state_r;
    logic [LINES-1:0]         valid_r;
    logic [LINES-1:0]         dirty_r;
    logic [TAG_W-1:0]         tag_r  [LINES];
    logic [31:0]              data_r [LINES];
    logic [TAG_W-1:0]         fetch_tag_r;
    logic                     mem_read_r;
    logic                     mem_write_r;
    logic [TAG_W+IDX_W-1:0]   mem_address_r;
    logic [31:0]              mem_writedata_r;

    logic [TAG_W-1:0]         tag_s;
    logic [IDX_W-1:0]         idx_s;
    logic [OFF_W-1:0]         off_s;
    logic                     access_s;
    logic                     hit_s;
    logic                     write_hit_s;
    logic                     busy_s;
    logic [7:0]               readdata_s;

    function automatic logic [7:0] get_byte(input logic [31:0] blk, input logic [OFF_W-1:0] off);
        return blk[{off, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] blk, input logic [OFF_W-1:0] off,
                                             input logic [7:0] b);
        logic [31:0] res;
        res = blk;
        res[{off, 3'b000} +: 8] = b;
        return res;
    endfunction

    assign tag_s = address[OFF_W+IDX_W +: TAG_W];
    assign idx_s = address[OFF_W +: IDX_W];
    assign off_s = address[OFF_W-1:0];

    // Hit detection, CPU stall and read-byte selection
    always_comb begin
        access_s    = read ^ write;
        hit_s       = access_s && valid_r[idx_s] && (tag_r[idx_s] == tag_s);
        write_hit_s = write && !read && hit_s && (state_r == IDLE);
        if (reset) begin
            busy_s     = 1'b0;
            readdata_s = 8'h00;
        end else begin
            busy_s = (access_s && !hit_s) || (state_r != IDLE);
            if (read && hit_s) begin
                readdata_s = get_byte(data_r[idx_s], off_s);
            end else begin
                readdata_s = 8'h00;
            end
        end
    end

    // Miss sequencer, line storage and registered memory-side requests
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            valid_r         <= '0;
            dirty_r         <= '0;
            fetch_tag_r     <= '0;
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            mem_address_r   <= '0;
            mem_writedata_r <= 32'h0000_0000;
            for (int i = 0; i < LINES; i++) begin
                tag_r[i]  <= '0;
                data_r[i] <= 32'h0000_0000;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (write_hit_s) begin
                        data_r[idx_s]  <= put_byte(data_r[idx_s], off_s, writedata);
                        dirty_r[idx_s] <= 1'b1;
                    end else if (access_s && !hit_s) begin
                        fetch_tag_r <= tag_s;
                        if (valid_r[idx_s] && dirty_r[idx_s]) begin
                            state_r         <= WRITEBACK;
                            mem_write_r     <= 1'b1;
                            mem_address_r   <= {tag_r[idx_s], idx_s};
                            mem_writedata_r <= data_r[idx_s];
                        end else begin
                            state_r       <= FETCH;
                            mem_read_r    <= 1'b1;
                            mem_address_r <= {tag_s, idx_s};
                        end
                    end
                end
                WRITEBACK: begin
                    if (!mem_busywait) begin
                        state_r         <= FETCH;
                        mem_write_r     <= 1'b0;
                        mem_read_r      <= 1'b1;
                        mem_address_r   <= {fetch_tag_r, mem_address_r[IDX_W-1:0]};
                        mem_writedata_r <= 32'h0000_0000;
                    end
                end
                FETCH: begin
                    // Line index comes from the latched request so a dropped CPU request still completes
                    if (!mem_busywait) begin
                        data_r[mem_address_r[IDX_W-1:0]]  <= mem_readdata;
                        tag_r[mem_address_r[IDX_W-1:0]]   <= fetch_tag_r;
                        valid_r[mem_address_r[IDX_W-1:0]] <= 1'b1;
                        dirty_r[mem_address_r[IDX_W-1:0]] <= 1'b0;
                        state_r                           <= IDLE;
                        mem_read_r                        <= 1'b0;
                        mem_address_r                     <= '0;
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    mem_read_r      <= 1'b0;
                    mem_write_r     <= 1'b0;
                    mem_address_r   <= '0;
                    mem_writedata_r <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign readdata      = readdata_s;
    assign busywait      = busy_s;
    assign mem_read      = mem_read_r;
    assign mem_write     = mem_write_r;
    assign mem_address   = mem_address_r;
    assign mem_writedata = mem_writedata_r;

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: 5-cycle block memory, transaction-level cache
// model producing a per-cycle expectation, directed cases then random traffic.
module tb_dcache_controller;

    localparam int MEM_LAT = 5;

    logic        clock;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    dcache_controller dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .write        (write),
        .address      (address),
        .writedata    (writedata),
        .readdata     (readdata),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h4433_2211;
        else if (i == 8) return 32'h8877_6655;
        else return 32'hA5C3_0F96 ^ (32'(i) * 32'h0101_0107);
    endfunction

    // Block memory: busy from the first request cycle, done on the MEM_LAT-th cycle
    logic [31:0] mem [64];
    logic        mem_init_done = 1'b0;
    int          lat_cnt = 0;
    int          wb_count = 0;
    int          rd_count = 0;
    logic [5:0]  last_wb_addr = 6'd0;
    logic [31:0] last_wb_data = 32'h0;
    logic [5:0]  last_rd_addr = 6'd0;

    assign mem_busywait = (mem_read || mem_write) && (lat_cnt < MEM_LAT - 1);
    assign mem_readdata = mem_read ? mem[mem_address] : 32'h0;

    always @(posedge clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end
        if (reset || !(mem_read || mem_write)) begin
            lat_cnt <= 0;
        end else if (lat_cnt < MEM_LAT - 1) begin
            lat_cnt <= lat_cnt + 1;
        end else begin
            lat_cnt <= 0;
            if (mem_write) begin
                mem[mem_address] <= mem_writedata;
                wb_count         <= wb_count + 1;
                last_wb_addr     <= mem_address;
                last_wb_data     <= mem_writedata;
            end else begin
                rd_count     <= rd_count + 1;
                last_rd_addr <= mem_address;
            end
        end
    end

    // Reference model: cache lines and memory image as plain arrays
    logic        mv [8];
    logic        md [8];
    logic [2:0]  mt [8];
    logic [31:0] mdat [8];
    logic [31:0] ref_mem [64];

    typedef struct packed {
        logic        busy;
        logic [7:0]  rdata;
        logic        mrd;
        logic        mwr;
        logic [5:0]  maddr;
        logic [31:0] mwdata;
    } exp_t;

    exp_t exp_cur;
    logic exp_on = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   obs_busy = 0;
    logic [7:0] last_rdata = 8'h00;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic b, input logic [7:0] rdv, input logic r, input logic w,
                                input logic [5:0] ad, input logic [31:0] wdv);
        exp_t e;
        e.busy = b; e.rdata = rdv; e.mrd = r; e.mwr = w; e.maddr = ad; e.mwdata = wdv;
        return e;
    endfunction

    // Per-cycle compare against the model's expectation
    initial begin
        forever begin
            @(negedge clock);
            if (exp_on) begin
                check("busywait", 32'(busywait), 32'(exp_cur.busy));
                check("readdata", 32'(readdata), 32'(exp_cur.rdata));
                check("mem_read", 32'(mem_read), 32'(exp_cur.mrd));
                check("mem_write", 32'(mem_write), 32'(exp_cur.mwr));
                check("mem_address", 32'(mem_address), 32'(exp_cur.maddr));
                if (!exp_cur.mrd) check("mem_writedata", mem_writedata, exp_cur.mwdata);
                obs_busy   = obs_busy + int'(busywait);
                last_rdata = readdata;
            end
        end
    end

    task automatic step(input exp_t e);
        exp_cur = e;
        exp_on  = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic do_op(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd);
        logic [2:0]  ix;
        logic [2:0]  tg;
        logic [1:0]  of;
        logic [31:0] line;
        ix = a[4:2]; tg = a[7:5]; of = a[1:0];
        read = rd; write = wr; address = a; writedata = wd;
        obs_busy = 0;
        if (rd == wr) begin
            step(mk(1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 32'h0));
        end else begin
            if (!(mv[ix] && mt[ix] == tg)) begin
                step(mk(1'b1, 8'h00, 1'b0, 1'b0, 6'd0, 32'h0));
                if (mv[ix] && md[ix]) begin
                    for (int k = 0; k < MEM_LAT; k++)
                        step(mk(1'b1, 8'h00, 1'b0, 1'b1, {mt[ix], ix}, mdat[ix]));
                    ref_mem[{mt[ix], ix}] = mdat[ix];
                end
                for (int k = 0; k < MEM_LAT; k++)
                    step(mk(1'b1, 8'h00, 1'b1, 1'b0, {tg, ix}, 32'h0));
                mdat[ix] = ref_mem[{tg, ix}];
                mt[ix] = tg; mv[ix] = 1'b1; md[ix] = 1'b0;
            end
            line = mdat[ix];
            step(mk(1'b0, rd ? line[of*8 +: 8] : 8'h00, 1'b0, 1'b0, 6'd0, 32'h0));
            if (wr) begin
                line[of*8 +: 8] = wd;
                mdat[ix] = line;
                md[ix] = 1'b1;
            end
        end
        exp_on = 1'b0;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0; md[i] = 1'b0; mt[i] = 3'd0; mdat[i] = 32'h0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int wb_before;
        int r;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        model_reset();
        reset = 1'b1; read = 1'b1; write = 1'b0; address = 8'h00; writedata = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busywait", 32'(busywait), 32'd0);
        check("reset_readdata", 32'(readdata), 32'd0);
        check("reset_mem_read", 32'(mem_read), 32'd0);
        check("reset_mem_write", 32'(mem_write), 32'd0);
        read = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;

        do_op(1'b1, 1'b0, 8'h00, 8'h00);
        check("clean_miss_busy", 32'(obs_busy), 32'd6);
        check("rd00_data", 32'(last_rdata), 32'h11);
        check("rd00_fetch_addr", 32'(last_rd_addr), 32'd0);
        check("rd00_no_wb", 32'(wb_count), 32'd0);

        do_op(1'b1, 1'b0, 8'h03, 8'h00);
        check("hit_busy", 32'(obs_busy), 32'd0);
        check("rd03_data", 32'(last_rdata), 32'h44);

        do_op(1'b0, 1'b1, 8'h01, 8'hAA);
        check("wr_hit_busy", 32'(obs_busy), 32'd0);
        do_op(1'b1, 1'b0, 8'h01, 8'h00);
        check("rd01_data", 32'(last_rdata), 32'hAA);

        do_op(1'b1, 1'b0, 8'h21, 8'h00);
        check("dirty_miss_busy", 32'(obs_busy), 32'd11);
        check("wb_addr", 32'(last_wb_addr), 32'd0);
        check("wb_data", last_wb_data, 32'h4433_AA11);
        check("rd21_fetch_addr", 32'(last_rd_addr), 32'd8);
        check("rd21_data", 32'(last_rdata), 32'h66);

        do_op(1'b1, 1'b1, 8'h10, 8'h77);
        check("both_busy", 32'(obs_busy), 32'd0);

        do_op(1'b1, 1'b0, 8'hFF, 8'h00);
        check("ff_fetch_addr", 32'(last_rd_addr), 32'd63);

        // Dirty the index-0 line, then abort its writeback with reset
        do_op(1'b0, 1'b1, 8'h21, 8'h5A);
        wb_before = wb_count;
        read = 1'b1; address = 8'h01;
        @(posedge clock);
        #1;
        check("wb_start_mem_write", 32'(mem_write), 32'd1);
        check("wb_start_addr", 32'(mem_address), 32'd8);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("abort_mem_write", 32'(mem_write), 32'd0);
        check("abort_busywait", 32'(busywait), 32'd0);
        check("abort_mem_read", 32'(mem_read), 32'd0);
        read = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();

        do_op(1'b1, 1'b0, 8'h21, 8'h00);
        check("post_reset_busy", 32'(obs_busy), 32'd6);
        check("post_reset_no_wb", 32'(wb_count), 32'(wb_before));
        check("post_reset_fetch_addr", 32'(last_rd_addr), 32'd8);
        check("post_reset_data", 32'(last_rdata), 32'h66);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      do_op(1'b1, 1'b0, 8'($urandom_range(0, 255)), 8'h00);
            else if (r < 9) do_op(1'b0, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            else            do_op(r[0], r[0], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the CPU data port and a 64-block x 32-bit block data memory.
- Presents the CPU the same byte-wide read/write/busywait protocol the CPU already uses. Hits are serviced with no stall.
- Misses are sequenced into block writeback and block fetch transactions against the memory's busywait handshake.

Parameters:
- TAG_W, 3, tag bits (address[7:5]).
- IDX_W, 3, index bits (address[4:2]); 2**IDX_W = 8 lines.
- OFF_W, 2, byte offset bits (address[1:0]); 4 bytes per line. TAG_W+IDX_W+OFF_W must equal 8.

Ports:
- clock  in  1  system clock, all state changes on posedge
- reset  in  1  asynchronous, active-high; clears all state
- read  in  1  CPU byte read request
- write  in  1  CPU byte write request
- address  in  8  CPU byte address
- writedata  in  8  CPU write byte
- readdata  out  8  CPU read byte
- busywait  out  1  CPU stall; CPU holds read/write/address/writedata stable while 1
- mem_read  out  1  block fetch request
- mem_write  out  1  block writeback request
- mem_address  out  6  block address {tag,index}
- mem_writedata  out  32  writeback block, byte0 in [7:0]
- mem_readdata  in  32  fetched block, byte0 in [7:0]
- mem_busywait  in  1  memory busy; rises combinationally with request, falls when transfer done

Behaviour:
- Storage per line: valid, dirty, tag[2:0], data[31:0].
- Access is defined as read XOR write. If read and write are both 1, no access occurs: busywait=0, no state change.
- hit = access && valid[idx] && tag[idx]==address[7:5]. This is combinational.
- readdata = byte address[1:0] of data[idx] when read && hit, else 8'h00.
- busywait = access && !hit, or state != IDLE. This is combinational.
- Read hit: zero stall; data is valid in the same cycle.
- Write hit: at posedge, the byte is written into the line and dirty=1. busywait stays 0.
- FSM states are IDLE, WRITEBACK and FETCH.
- In IDLE:
  - On a miss with valid && dirty, go to WRITEBACK at the next posedge.
  - On a miss otherwise, go to FETCH at the next posedge.
- In WRITEBACK:
  - mem_write=1, mem_address={tag[idx],idx}, mem_writedata=data[idx].
  - At the first posedge with mem_busywait==0, go to FETCH.
- In FETCH:
  - mem_read=1, mem_address={address[7:5],idx}.
  - At the first posedge with mem_busywait==0: data[idx]<=mem_readdata, tag<=address[7:5], valid<=1, dirty<=0, state<=IDLE.
- Next cycle in IDLE the access hits. A read returns data; a write merges its byte and sets dirty at that edge.
- Miss latency is 1 cycle + mem latency per transaction + 1 re-access cycle. With a 5-cycle memory:
  - Clean miss: busywait high 6 cycles.
  - Dirty miss: busywait high 11 cycles.
- mem_read and mem_write are never both 1. Both are 0 in IDLE. mem_address and mem_writedata are 0 in IDLE.
- Reset (asynchronous, any state): state=IDLE, all valid=0, dirty=0, tags=0, data=0, mem_read=0, mem_write=0.
  - An in-flight writeback is abandoned.
  - While reset=1, no accesses are serviced (busywait=0, readdata=0).
- Boundary conditions:
  - Address 8'hFF maps to index 7, offset 3.
  - Tag 0 with valid=0 must not hit after reset.
  - A request dropped by the CPU mid-miss is a protocol violation; the FSM still completes the current transaction.

Test Plan:
- Reset, then read addr 8'h00 with mem block 0 = 32'h44332211 -> busywait high, mem_read=1 with mem_address=6'd0, then readdata=8'h11, no mem_write issued.
- After the above, read 8'h03 -> hit, busywait stays 0, readdata=8'h44 in the same cycle.
- Write 8'hAA to 8'h01 (hit) -> no mem activity. Then read 8'h01 -> 8'hAA.
- Read 8'h21 (same index 0, tag 1) -> mem_write with mem_address=6'd0 and mem_writedata=32'h4433AA11, then mem_read with mem_address=6'd8, then correct byte returned. With a 5-cycle memory, busywait is high for 11 cycles.
- Assert read and write together on 8'h10 -> busywait=0, no mem request, cache contents unchanged.
- Assert reset during WRITEBACK -> mem_write drops immediately. Afterwards read 8'h21 misses (valid cleared) and fetches block 8 without writeback.
